// File: rtl/wt_mem_req_arbiter_if.sv
// Request/return bundle between the I$/D$ request ports, the memory
// adapter input and the return-valid strobes of wt_mem_req_arbiter.
// Ports: slave = arbiter view, master = surrounding system view.
interface wt_mem_req_arbiter_if #(
    parameter int PayloadWidth = 128,
    parameter int TidWidth     = 2
);
    logic                    icache_data_req_i;
    logic                    icache_data_ack_o;
    logic [PayloadWidth-1:0] icache_data_i;
    logic                    dcache_data_req_i;
    logic                    dcache_data_ack_o;
    logic [PayloadWidth-1:0] dcache_data_i;
    logic                    mem_data_req_o;
    logic                    mem_data_ack_i;
    logic [PayloadWidth-1:0] mem_data_o;
    logic                    mem_src_o;
    logic                    rtrn_vld_i;
    logic [TidWidth-1:0]     rtrn_tid_i;
    logic                    icache_rtrn_vld_o;
    logic                    dcache_rtrn_vld_o;
    logic                    busy_o;
    logic                    err_o;

    modport slave (
        input  icache_data_req_i, icache_data_i,
        input  dcache_data_req_i, dcache_data_i,
        input  mem_data_ack_i, rtrn_vld_i, rtrn_tid_i,
        output icache_data_ack_o, dcache_data_ack_o,
        output mem_data_req_o, mem_data_o, mem_src_o,
        output icache_rtrn_vld_o, dcache_rtrn_vld_o,
        output busy_o, err_o
    );

    modport master (
        output icache_data_req_i, icache_data_i,
        output dcache_data_req_i, dcache_data_i,
        output mem_data_ack_i, rtrn_vld_i, rtrn_tid_i,
        input  icache_data_ack_o, dcache_data_ack_o,
        input  mem_data_req_o, mem_data_o, mem_src_o,
        input  icache_rtrn_vld_o, dcache_rtrn_vld_o,
        input  busy_o, err_o
    );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Shares the memory-adapter request channel between the write-through I$
// and D$: one-entry output register, round-robin arbitration, per-requester
// outstanding counters and TID-based return routing.
// Ports: clk_i, rst_i (async, active high), bus (wt_mem_req_arbiter_if.slave).
// Option: define WT_ARB_ICACHE_PRIO_EN for fixed I$ priority instead of RR.
module wt_mem_req_arbiter #(
    parameter int PayloadWidth   = 128,
    parameter int TidWidth       = 2,
    parameter int IcacheTxId     = 0,
    parameter int MaxOutstanding = 4
) (
    input logic clk_i,
    input logic rst_i,
    wt_mem_req_arbiter_if.slave bus
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [TidWidth-1:0] ITid = TidWidth'(IcacheTxId);

    typedef enum logic {
        EMPTY,
        FULL
    } state_e;

    state_e                  state;
    logic                    last_src;
    logic [CntW-1:0]         icnt;
    logic [CntW-1:0]         dcnt;
    logic                    err;
    logic [PayloadWidth-1:0] data_q;
    logic                    src_q;

    logic slot;
    logic i_elig;
    logic d_elig;
    logic sel_d;
    logic gnt;
    logic i_gnt;
    logic d_gnt;
    logic i_ret;
    logic d_ret;

    always_comb begin
        slot   = (state == EMPTY) || bus.mem_data_ack_i;
        i_elig = bus.icache_data_req_i && (icnt < CntMax);
        d_elig = bus.dcache_data_req_i && (dcnt < CntMax);
`ifdef WT_ARB_ICACHE_PRIO_EN
        sel_d  = d_elig && !i_elig;
`else
        // on a tie the D$ wins only if the I$ was granted last
        sel_d  = d_elig && (!i_elig || !last_src);
`endif
        gnt    = slot && (i_elig || d_elig);
        i_gnt  = gnt && !sel_d;
        d_gnt  = gnt && sel_d;
        i_ret  = bus.rtrn_vld_i && (bus.rtrn_tid_i == ITid);
        d_ret  = bus.rtrn_vld_i && (bus.rtrn_tid_i != ITid);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= EMPTY;
            data_q   <= '0;
            src_q    <= 1'b0;
            last_src <= 1'b1;
            icnt     <= '0;
            dcnt     <= '0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: if (gnt) state <= FULL;
                FULL:  if (bus.mem_data_ack_i && !gnt) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (gnt) begin
                data_q   <= sel_d ? bus.dcache_data_i : bus.icache_data_i;
                src_q    <= sel_d;
                last_src <= sel_d;
            end
            // a return to an idle requester is dropped, not wrapped
            icnt <= icnt + CntW'(i_gnt) - CntW'(i_ret && (icnt != '0));
            dcnt <= dcnt + CntW'(d_gnt) - CntW'(d_ret && (dcnt != '0));
            if ((i_ret && (icnt == '0)) || (d_ret && (dcnt == '0))) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.icache_data_ack_o = i_gnt;
    assign bus.dcache_data_ack_o = d_gnt;
    assign bus.mem_data_req_o    = (state == FULL);
    assign bus.mem_data_o        = data_q;
    assign bus.mem_src_o         = src_q;
    assign bus.icache_rtrn_vld_o = i_ret;
    assign bus.dcache_rtrn_vld_o = d_ret;
    assign bus.busy_o = (state == FULL) || (icnt != '0) || (dcnt != '0);
    assign bus.err_o  = err;
endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: reference model of the
// arbitration rules plus a scoreboard queue checked by a monitor.
module tb_wt_mem_req_arbiter;
    localparam int PW  = 128;
    localparam int TW  = 2;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wt_mem_req_arbiter_if #(.PayloadWidth(PW), .TidWidth(TW)) bus ();

    wt_mem_req_arbiter #(
        .PayloadWidth(PW),
        .TidWidth(TW),
        .IcacheTxId(0),
        .MaxOutstanding(MAX)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          src;
    } item_t;

    item_t sbq[$];

    // reference model state
    bit m_full;
    bit m_last;
    bit m_err;
    int m_icnt;
    int m_dcnt;
    bit i_acked;
    bit d_acked;

    task automatic chk(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_full  = 0;
        m_last  = 1;
        m_err   = 0;
        m_icnt  = 0;
        m_dcnt  = 0;
        i_acked = 0;
        d_acked = 0;
        sbq.delete();
    endtask

    task automatic cycle(input bit new_i, input bit new_d, input bit mack,
                         input bit ret, input logic [TW-1:0] tid);
        bit slot, ie, de, grant, pick_d, gi, gd, ri, rd;
        item_t it;
        @(negedge clk);
        if (i_acked) bus.icache_data_req_i = 1'b0;
        if (d_acked) bus.dcache_data_req_i = 1'b0;
        if (new_i && !bus.icache_data_req_i) begin
            bus.icache_data_req_i = 1'b1;
            bus.icache_data_i     = rnd_payload();
        end
        if (new_d && !bus.dcache_data_req_i) begin
            bus.dcache_data_req_i = 1'b1;
            bus.dcache_data_i     = rnd_payload();
        end
        bus.mem_data_ack_i = mack;
        bus.rtrn_vld_i     = ret;
        bus.rtrn_tid_i     = tid;
        #1;
        slot  = !m_full || mack;
        ie    = bus.icache_data_req_i && (m_icnt < MAX);
        de    = bus.dcache_data_req_i && (m_dcnt < MAX);
        grant = slot && (ie || de);
        if (ie && de) begin
`ifdef WT_ARB_ICACHE_PRIO_EN
            pick_d = 0;
`else
            pick_d = (m_last == 0);
`endif
        end else begin
            pick_d = de;
        end
        gi = grant && !pick_d;
        gd = grant && pick_d;
        ri = ret && (tid == 0);
        rd = ret && (tid != 0);
        chk("icache_ack", bus.icache_data_ack_o, gi);
        chk("dcache_ack", bus.dcache_data_ack_o, gd);
        chk("icache_rtrn", bus.icache_rtrn_vld_o, ri);
        chk("dcache_rtrn", bus.dcache_rtrn_vld_o, rd);
        chk("mem_req", bus.mem_data_req_o, m_full);
        chk("busy", bus.busy_o, m_full || m_icnt > 0 || m_dcnt > 0);
        chk("err", bus.err_o, m_err);
        if ((ri && m_icnt == 0) || (rd && m_dcnt == 0)) m_err = 1;
        m_icnt = m_icnt + int'(gi) - int'(ri && m_icnt > 0);
        m_dcnt = m_dcnt + int'(gd) - int'(rd && m_dcnt > 0);
        if (grant) begin
            it.data = pick_d ? bus.dcache_data_i : bus.icache_data_i;
            it.src  = pick_d;
            sbq.push_back(it);
            m_last = pick_d;
            m_full = 1;
        end else if (mack) begin
            m_full = 0;
        end
        i_acked = gi;
        d_acked = gd;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (m_icnt == 0 && m_dcnt == 0 && !m_full && !i_acked && !d_acked
                && !bus.icache_data_req_i && !bus.dcache_data_req_i) break;
            if (m_icnt > 0)      cycle(0, 0, 1, 1, TW'(0));
            else if (m_dcnt > 0) cycle(0, 0, 1, 1, TW'(2));
            else                 cycle(0, 0, 1, 0, TW'(0));
        end
    endtask

    // monitor: every valid output is checked against the scoreboard front,
    // which also proves the register holds while not consumed
    always @(negedge clk) begin
        #2;
        if (!rst && bus.mem_data_req_o) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: output valid with no expected item at %0t",
                         $time);
            end else begin
                chk("mem_data", bus.mem_data_o, sbq[0].data);
                chk("mem_src", bus.mem_src_o, sbq[0].src);
                if (bus.mem_data_ack_i) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        int r;
        bus.icache_data_req_i = 0;
        bus.icache_data_i     = '0;
        bus.dcache_data_req_i = 0;
        bus.dcache_data_i     = '0;
        bus.mem_data_ack_i    = 0;
        bus.rtrn_vld_i        = 0;
        bus.rtrn_tid_i        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_mem_req", bus.mem_data_req_o, 0);
        chk("rst_mem_data", bus.mem_data_o, 0);
        chk("rst_mem_src", bus.mem_src_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_iack", bus.icache_data_ack_o, 0);
        rst = 1'b0;

        // both requesting, adapter always ready
        repeat (8) cycle(1, 1, 1, 0, TW'(0));
        drain();

        // single D$ request held in the output register for 5 cycles
        cycle(0, 1, 0, 0, TW'(0));
        repeat (5) cycle(0, 0, 0, 0, TW'(0));
        cycle(0, 0, 1, 0, TW'(0));
        drain();

        // I$ fills its outstanding budget, then one return frees a slot
        repeat (6) cycle(1, 0, 1, 0, TW'(0));
        cycle(1, 0, 1, 1, TW'(0));
        cycle(1, 0, 1, 0, TW'(0));
        drain();

        // D$ grant and D$ return in the same cycle
        cycle(0, 1, 1, 0, TW'(0));
        cycle(0, 1, 1, 0, TW'(0));
        cycle(0, 1, 1, 1, TW'(1));
        cycle(0, 0, 1, 0, TW'(0));
        drain();

        // underflow: sticky error
        cycle(0, 0, 1, 1, TW'(0));
        repeat (3) cycle(0, 0, 1, 0, TW'(0));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 3);
            if (r == 1 && m_icnt > 0)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, 1, TW'(0));
            else if (r == 2 && m_dcnt > 0)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, 1, TW'($urandom_range(1, 3)));
            else
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, 0, TW'(0));
        end

        // load up, then asynchronous reset mid-cycle
        repeat (3) cycle(1, 1, 0, 0, TW'(0));
        #2;
        bus.icache_data_req_i = 0;
        bus.dcache_data_req_i = 0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_mem_req", bus.mem_data_req_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_err", bus.err_o, 0);
        chk("arst_mem_data", bus.mem_data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cycle(1, 1, 1, 0, TW'(0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wt_mem_req_arbiter.md
# wt_mem_req_arbiter

Shares the single memory-adapter request channel between the write-through I$ and D$. It sits between the cache request ports and the adapter input. It registers the winning request in a one-entry output stage and arbitrates round-robin by default. It throttles each requester with an outstanding-transaction counter and routes return-valid strobes back to the issuing cache by transaction ID.

## Interface
Parameters:
- PayloadWidth, 128: width of the opaque request payload (address, size, type, tid, wdata) forwarded unmodified.
- TidWidth, 2: transaction-ID width on the return channel.
- IcacheTxId, 0: return TID belonging to the I$; every other TID belongs to the D$.
- MaxOutstanding, 4: maximum in-flight transactions per requester (≥1).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- icache_data_req_i  in  1  I$ request valid; held until acked.
- icache_data_ack_o  out  1  I$ request accepted (1-cycle pulse).
- icache_data_i  in  PayloadWidth  I$ request payload.
- dcache_data_req_i  in  1  D$ request valid; held until acked.
- dcache_data_ack_o  out  1  D$ request accepted (1-cycle pulse).
- dcache_data_i  in  PayloadWidth  D$ request payload.
- mem_data_req_o  out  1  output register valid.
- mem_data_ack_i  in  1  adapter consumed the output register.
- mem_data_o  out  PayloadWidth  registered payload.
- mem_src_o  out  1  source of mem_data_o: 0 = I$, 1 = D$.
- rtrn_vld_i  in  1  return transaction valid.
- rtrn_tid_i  in  TidWidth  return transaction ID.
- icache_rtrn_vld_o  out  1  rtrn_vld_i && tid == IcacheTxId (combinational).
- dcache_rtrn_vld_o  out  1  rtrn_vld_i && tid != IcacheTxId (combinational).
- busy_o  out  1  output register full, or either counter nonzero.
- err_o  out  1  sticky: a return arrived for a requester whose counter was 0.

## Operation
- Output stage states: EMPTY and FULL.
  - EMPTY → FULL on grant.
  - FULL → EMPTY on mem_data_ack_i with no grant.
  - FULL → FULL on mem_data_ack_i with grant (back-to-back reload).
  - FULL without mem_data_ack_i: hold; no grant.
- Grant is possible when the state is EMPTY, or FULL && mem_data_ack_i.
- Eligibility: requester's req_i is high and its counter < MaxOutstanding.
- Winner selection: round-robin via the last_src register. With both eligible, the one not granted last wins. With one eligible, it wins. last_src updates only on grant.
- On grant:
  - capture the winner's payload into mem_data_o and its source into mem_src_o;
  - pulse the winner's data_ack_o in the same cycle (combinational from the grant condition);
  - increment the winner's counter.
- Return: decrement the counter of the routed requester.
  - Increment and decrement of the same counter in one cycle → net unchanged.
  - Decrement at 0 → counter stays 0 and err_o is set; err_o clears only on reset.
- Counter width: $clog2(MaxOutstanding+1); never exceeds MaxOutstanding.
- Payload is never modified; mem_data_o is stable while mem_data_req_o && !mem_data_ack_i.

## Timing
- Reset values:
  - mem_data_req_o = 0, mem_data_o = 0, mem_src_o = 0;
  - both counters = 0, last_src = 1 (D$), so the I$ wins the first tie;
  - err_o = 0, busy_o = 0;
  - ack outputs 0; return valids follow their inputs.
- Request latency: req_i high in cycle N with an idle stage → ack_o in N, mem_data_req_o in N+1.
- Throughput: one request per cycle with mem_data_ack_i held high.
- The return path has zero latency. The counter update is visible in the next cycle, so a full requester becomes eligible one cycle after its return.
- Asynchronous reset mid-operation discards the output register and zeroes the counters. In-flight returns after reset count as underflow and set err_o; the system must reset the adapter together with this block.

## Configuration
- WT_ARB_ICACHE_PRIO_EN:
  - Defined: fixed priority; an eligible I$ always beats the D$, and last_src is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then I$ and D$ request together with mem_data_ack_i=1 → grants alternate I$, D$, I$, D$ one per cycle; mem_src_o 0,1,0,1. With WT_ARB_ICACHE_PRIO_EN: D$ is starved and mem_src_o stays 0.
- Single D$ request, mem_data_ack_i low for 5 cycles → dcache_data_ack_o pulses once in cycle 0; mem_data_o stable cycles 1–6; EMPTY after the ack.
- MaxOutstanding=4, I$ issues 4 with no returns → 5th request not acked. Return TID 0 in cycle K → icache_rtrn_vld_o=1 in K, 5th acked in K+1.
- Grant and TID=1 return in the same cycle with D$ counter=2 → counter stays 2; dcache_rtrn_vld_o=1.
- Return TID 0 with I$ counter=0 → err_o=1 and stays 1; counter stays 0.
- Assert rst_i while FULL with counters 3/2 → mem_data_req_o=0, counters 0, busy_o=0 immediately (asynchronous).
